md_unit: RTL and testbench

Multiply/divide unit for the five-stage MIPS pipeline, sitting in EX directly downstream of the instruction decoder. It consumes the decoded HI/LO-class operations (mult, multu, div, divu, mthi, mtlo, msub) with the two register operands. It runs multi-cycle multiply and divide against architectural HI/LO registers and raises `busy` so hazard logic stalls any following HI/LO-class instruction.

---
 rtl/md_unit.sv | 139 +++++++++++++
 tb/tb_md_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit driving architectural HI/LO for the MIPS EX stage.
// Define MD_MSUB_EN to enable MSUB (md_op 0111); otherwise that code is treated as "none".
module md_unit #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_DIVU = 4'd4;
   localparam logic [3:0] OP_MTHI = 4'd5;
   localparam logic [3:0] OP_MTLO = 4'd6;
   localparam logic [3:0] OP_MSUB = 4'd7;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic          r_done;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic [3:0]    r_op;
   logic [31:0]   r_a;
   logic [31:0]   r_b;

   logic          w_valid;
   logic [63:0]   w_prod_s;
   logic [63:0]   w_prod_u;
   logic [63:0]   w_mul_res;
   logic          w_sdiv;
   logic [31:0]   w_ua;
   logic [31:0]   w_ub;
   logic [31:0]   w_uq;
   logic [31:0]   w_ur;
   logic [31:0]   w_q;
   logic [31:0]   w_r;

   // Results come only from the captured operands, never the live inputs.
   assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
   assign w_prod_u = {32'b0, r_a} * {32'b0, r_b};

`ifdef MD_MSUB_EN
   assign w_valid   = (md_op != 4'd0) && (md_op <= OP_MSUB);
   assign w_mul_res = (r_op == OP_MSUB) ? ({r_hi, r_lo} - w_prod_s) :
                      (r_op == 4'd2)    ? w_prod_u : w_prod_s;
`else
   assign w_valid   = (md_op != 4'd0) && (md_op < OP_MSUB);
   assign w_mul_res = (r_op == 4'd2) ? w_prod_u : w_prod_s;
`endif

   // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   assign w_sdiv = (r_op == OP_DIV);
   assign w_ua   = (w_sdiv && r_a[31]) ? (~r_a + 32'd1) : r_a;
   assign w_ub   = (w_sdiv && r_b[31]) ? (~r_b + 32'd1) : r_b;
   assign w_uq   = w_ua / w_ub;
   assign w_ur   = w_ua % w_ub;
   assign w_q    = (w_sdiv && (r_a[31] ^ r_b[31])) ? (~w_uq + 32'd1) : w_uq;
   assign w_r    = (w_sdiv && r_a[31]) ? (~w_ur + 32'd1) : w_ur;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && w_valid) begin
                  r_op <= md_op;
                  r_a  <= a;
                  r_b  <= b;
                  case (md_op)
                     OP_MTHI: r_hi <= a;
                     OP_MTLO: r_lo <= a;
                     OP_DIV, OP_DIVU: begin
                        r_state <= S_DIV;
                        r_busy  <= 1'b1;
                        r_cnt   <= CW'(DIV_CYCLES);
                     end
                     default: begin
                        r_state <= S_MUL;
                        r_busy  <= 1'b1;
                        r_cnt   <= CW'(MUL_CYCLES);
                     end
                  endcase
               end
            end
            S_MUL, S_DIV: begin
               if (r_cnt == CW'(1)) begin
                  if (r_state == S_MUL) begin
                     {r_hi, r_lo} <= w_mul_res;
                  end else if (r_b != 32'd0) begin
                     r_hi <= w_r;
                     r_lo <= w_q;
                  end
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver pushes expected HI/LO and busy length per op,
// monitor pops on every done pulse. Honors MD_MSUB_EN the same way as the design.
module tb_md_unit;

   localparam int MUL = 5;
   localparam int DIV = 10;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;

   sb_t         sbq[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          bcnt  = 0;
   logic [31:0] m_hi, m_lo;

   md_unit #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: counts busy cycles and checks each done against the oldest expectation.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt = 0;
      end else begin
         if (busy) bcnt++;
         if (done) begin
            if (sbq.size() == 0) begin
               chk("spurious_done", 64'd1, 64'd0);
            end else begin
               sb_t e;
               e = sbq.pop_front();
               chk("hi", {32'd0, hi}, {32'd0, e.hi});
               chk("lo", {32'd0, lo}, {32'd0, e.lo});
               chk("busy_cycles", 64'(bcnt), 64'(e.cyc));
            end
            bcnt = 0;
         end
      end
   end

   // Reference model: plain 64-bit arithmetic on the architectural rules.
   task automatic model(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        output int lat);
      longint q, r;
      logic [63:0] p;
      lat = 0;
      case (op)
         4'd1: begin
            p = 64'(longint'($signed(av)) * longint'($signed(bv)));
            {m_hi, m_lo} = p; lat = MUL;
         end
         4'd2: begin
            p = {32'd0, av} * {32'd0, bv};
            {m_hi, m_lo} = p; lat = MUL;
         end
         4'd3: begin
            if (bv != 0) begin
               q = longint'($signed(av)) / longint'($signed(bv));
               r = longint'($signed(av)) % longint'($signed(bv));
               m_lo = q[31:0]; m_hi = r[31:0];
            end
            lat = DIV;
         end
         4'd4: begin
            if (bv != 0) begin m_lo = av / bv; m_hi = av % bv; end
            lat = DIV;
         end
         4'd5: m_hi = av;
         4'd6: m_lo = av;
`ifdef MD_MSUB_EN
         4'd7: begin
            p = {m_hi, m_lo} - 64'(longint'($signed(av)) * longint'($signed(bv)));
            {m_hi, m_lo} = p; lat = MUL;
         end
`endif
         default: lat = 0;
      endcase
   endtask

   // Called at a negedge; returns at the negedge before the next possible accept.
   task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
      int lat;
      sb_t e;
      model(op, av, bv, lat);
      start = 1'b1; md_op = op; a = av; b = bv;
      if (lat > 0) begin
         e.hi = m_hi; e.lo = m_lo; e.cyc = lat;
         sbq.push_back(e);
      end
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      if (lat == 0) begin
         chk("nobusy", {63'd0, busy}, 64'd0);
         chk("hi_imm", {32'd0, hi}, {32'd0, m_hi});
         chk("lo_imm", {32'd0, lo}, {32'd0, m_lo});
      end
      repeat (lat) @(negedge clk);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int t;
      logic [3:0] op;
      rst_n = 1'b0; start = 1'b0; md_op = 4'd0; a = '0; b = '0;
      m_hi = '0; m_lo = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);

      // Accept on the first edge after release, then reset mid-op.
      rst_n = 1'b1;
      start = 1'b1; md_op = 4'd1; a = 32'd3; b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("mid_busy", {63'd0, busy}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_hilo", {hi, lo}, 64'd0);
      sbq.delete();
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("post_rst_hilo", {hi, lo}, 64'd0);

      issue(4'd1, 32'hFFFF_FFFF, 32'd2);
      issue(4'd2, 32'hFFFF_FFFF, 32'd2);
      issue(4'd3, 32'hFFFF_FFF9, 32'd2);
      issue(4'd5, 32'h11, 32'd0);
      issue(4'd6, 32'h22, 32'd0);
      issue(4'd4, 32'd7, 32'd0);
      issue(4'd5, 32'h5, 32'd0);
      issue(4'd6, 32'h10, 32'd0);
      issue(4'd7, 32'd2, 32'd3);
      chk("msub_hilo", {hi, lo}, {m_hi, m_lo});

      // DIV start while MULT busy must be ignored.
      begin
         int lat;
         sb_t e;
         model(4'd1, 32'd1234, 32'hFFFF_FFFE, lat);
         e.hi = m_hi; e.lo = m_lo; e.cyc = lat;
         sbq.push_back(e);
         start = 1'b1; md_op = 4'd1; a = 32'd1234; b = 32'hFFFF_FFFE;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         start = 1'b1; md_op = 4'd3; a = 32'd100; b = 32'd7;
         @(negedge clk);
         start = 1'b0;
         repeat (MUL - 2) @(negedge clk);
      end
      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(4'd0, 32'h1, 32'h1);
      issue(4'd9, 32'h1, 32'h1);

      for (int i = 0; i < 150; i++) begin
         int r;
         r = $urandom_range(0, 19);
         op = (r < 16) ? 4'((r % 7) + 1) : 4'($urandom_range(0, 15));
         issue(op, pick(), pick());
      end

      t = 0;
      while (sbq.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain_timeout", 64'(sbq.size()), 64'd0);
      chk("final_hilo", {hi, lo}, {m_hi, m_lo});
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
